starship_rom_port: RTL

Request/response front-end that sits directly upstream of the boot/debug mask ROM macro. It holds the macro's `me`/`oe`/`address` pins and captures the `q` word one cycle after each access. Word or two-word burst reads arrive on a valid/ready channel. Returned words are buffered in a small response FIFO, so the ROM is never accessed without space for its result.

---
 rtl/starship_rom_port_if.sv | 16 +
 rtl/starship_rom_port.sv | 87 ++++++++
 2 files changed

// File: rtl/starship_rom_port_if.sv
// starship_rom_port_if: request/response channel bundle between a requester and the ROM port
interface starship_rom_port_if #(parameter int ADDR_BITS = 11) ();
  logic                 req_valid;
  logic                 req_ready;
  logic [ADDR_BITS+1:0] req_addr;
  logic [1:0]           req_size;
  logic                 resp_valid;
  logic                 resp_ready;
  logic [31:0]          resp_data;
  logic                 resp_last;
  logic                 resp_err;
  modport master (output req_valid, req_addr, req_size, resp_ready,
                  input  req_ready, resp_valid, resp_data, resp_last, resp_err);
  modport slave  (input  req_valid, req_addr, req_size, resp_ready,
                  output req_ready, resp_valid, resp_data, resp_last, resp_err);
endinterface

// File: rtl/starship_rom_port.sv
// starship_rom_port: credit-gated word/burst reader in front of a synchronous mask ROM with response FIFO
module starship_rom_port #(
  parameter int ADDR_BITS  = 11,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clock,
  input  logic                 reset_n,
  starship_rom_port_if.slave   bus,
  output logic                 rom_me,
  output logic                 rom_oe,
  output logic [ADDR_BITS-1:0] rom_address,
  input  logic [31:0]          rom_q
);
  localparam int PW = $clog2(FIFO_DEPTH);
  typedef enum logic {IDLE, ISSUE} state_t;
  state_t state, state_nxt;
  logic [ADDR_BITS-1:0] base;
  logic two, err, idx;
  logic accept, issue, issue_last, req_err;
  logic iss, iss_err, iss_last, cap, cap_err, cap_last;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0] count;
  logic [PW+1:0] pending;
  logic [33:0] mem [FIFO_DEPTH];
  logic [33:0] head;
  logic pop;
  assign bus.req_ready = state == IDLE;
  assign accept = bus.req_valid && bus.req_ready;
  assign req_err = bus.req_size[1] || |bus.req_addr[1:0] || (bus.req_size == 2'd1 && bus.req_addr[2]);
  // beats being issued or captured this cycle still need a FIFO slot
  assign pending = (PW+2)'(count) + (PW+2)'(iss) + (PW+2)'(cap);
  assign issue = state == ISSUE && pending < (PW+2)'(FIFO_DEPTH);
  assign issue_last = !two || idx;
  always_comb begin
    state_nxt = accept ? ISSUE : (issue && issue_last) ? IDLE : state;
  end
  assign pop = bus.resp_valid && bus.resp_ready;
  assign bus.resp_valid = count != '0;
  assign head = bus.resp_valid ? mem[rd_ptr] : '0;
  assign bus.resp_data = head[33:2];
  assign bus.resp_err = head[1];
  assign bus.resp_last = head[0];
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      base        <= '0;
      two         <= 1'b0;
      err         <= 1'b0;
      idx         <= 1'b0;
      iss         <= 1'b0;
      iss_err     <= 1'b0;
      iss_last    <= 1'b0;
      cap         <= 1'b0;
      cap_err     <= 1'b0;
      cap_last    <= 1'b0;
      rom_me      <= 1'b0;
      rom_oe      <= 1'b0;
      rom_address <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        base <= bus.req_addr[ADDR_BITS+1:2];
        two  <= bus.req_size == 2'd1 && !req_err;
        err  <= req_err;
        idx  <= 1'b0;
      end else if (issue) idx <= 1'b1;
      iss      <= issue;
      iss_err  <= err;
      iss_last <= issue_last;
      rom_me   <= issue && !err;
      if (issue && !err) rom_address <= base + ADDR_BITS'(idx);
      cap      <= iss;
      cap_err  <= iss_err;
      cap_last <= iss_last;
      rom_oe   <= iss && !iss_err;
      if (cap) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + (PW+1)'(cap) - (PW+1)'(pop);
    end
  end
  always_ff @(posedge clock) begin
    if (cap) mem[wr_ptr] <= {cap_err ? 32'd0 : rom_q, cap_err, cap_last};
  end
endmodule
